// File: rtl/fork_join_ctrl.sv
// Fork/join controller: launches a set of worker channels with one request and
// releases the parent according to JOIN_ALL / JOIN_ANY / JOIN_NONE, with kill and timeout.
module fork_join_ctrl #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned TMO_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fork_req,
    input  logic [N_CH-1:0]          fork_mask,
    input  logic [1:0]               join_mode,
    input  logic                     kill_on_join,
    input  logic [TMO_W-1:0]         timeout,
    input  logic [N_CH-1:0]          ch_done,
    output logic                     fork_ack,
    output logic [N_CH-1:0]          ch_start,
    output logic [N_CH-1:0]          ch_kill,
    output logic [N_CH-1:0]          pending,
    output logic                     busy,
    output logic                     joined,
    output logic [$clog2(N_CH)-1:0]  join_first,
    output logic                     timed_out,
    output logic [TMO_W-1:0]         elapsed
);

    localparam int unsigned FW = $clog2(N_CH);
    localparam logic [TMO_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [TMO_W-1:0]  cnt, cnt_d;
    logic [TMO_W-1:0]  tmo_r, tmo_d;
    logic              any_r, any_d;
    logic              kill_r, kill_d;

    logic              fork_ack_d, joined_d, timed_out_d;
    logic [N_CH-1:0]   ch_start_d, ch_kill_d, pending_d;
    logic [FW-1:0]     join_first_d;
    logic [TMO_W-1:0]  elapsed_d;

    logic [N_CH-1:0]   done_v, remain;
    logic [TMO_W-1:0]  cnt_inc;
    logic              tmo_hit, join_hit;

    function automatic logic [FW-1:0] lowest(input logic [N_CH-1:0] v);
        lowest = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) lowest = FW'(i);
        end
    endfunction

    // Done pulses only count for launched channels; counter saturates.
    assign done_v  = ch_done & pending;
    assign remain  = pending & ~done_v;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + TMO_W'(1);
    assign tmo_hit = (tmo_r != '0) && (cnt_inc == tmo_r);

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        tmo_d        = tmo_r;
        any_d        = any_r;
        kill_d       = kill_r;
        pending_d    = pending;
        elapsed_d    = elapsed;
        join_first_d = join_first;
        fork_ack_d   = 1'b0;
        ch_start_d   = '0;
        ch_kill_d    = '0;
        joined_d     = 1'b0;
        timed_out_d  = 1'b0;
        join_hit     = 1'b0;

        unique case (state)
            IDLE: begin
                if (fork_req) begin
                    fork_ack_d = 1'b1;
                    ch_start_d = fork_mask;
                    pending_d  = fork_mask;
                    cnt_d      = '0;
                    elapsed_d  = '0;
                    tmo_d      = timeout;
                    any_d      = (join_mode == 2'd1);
                    kill_d     = kill_on_join;
                    if (fork_mask == '0) begin
                        joined_d = 1'b1;
                    end else if (join_mode == 2'd2) begin
                        joined_d = 1'b1;
                        state_d  = DRAIN;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end

            WAIT: begin
                cnt_d     = cnt_inc;
                pending_d = remain;
                join_hit  = any_r ? (done_v != '0) : (remain == '0);
                // A join on the same edge as the timeout wins.
                if (join_hit) begin
                    joined_d  = 1'b1;
                    elapsed_d = cnt_inc;
                    if (any_r) join_first_d = lowest(done_v);
                    if (any_r && kill_r) begin
                        ch_kill_d = remain;
                        pending_d = '0;
                        state_d   = IDLE;
                    end else begin
                        state_d   = (remain == '0) ? IDLE : DRAIN;
                    end
                end else if (tmo_hit) begin
                    timed_out_d = 1'b1;
                    ch_kill_d   = remain;
                    pending_d   = '0;
                    state_d     = IDLE;
                end
            end

            DRAIN: begin
                cnt_d     = cnt_inc;
                pending_d = remain;
                if (remain == '0) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    timed_out_d = 1'b1;
                    ch_kill_d   = remain;
                    pending_d   = '0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tmo_r      <= '0;
            any_r      <= 1'b0;
            kill_r     <= 1'b0;
            fork_ack   <= 1'b0;
            ch_start   <= '0;
            ch_kill    <= '0;
            pending    <= '0;
            busy       <= 1'b0;
            joined     <= 1'b0;
            join_first <= '0;
            timed_out  <= 1'b0;
            elapsed    <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            tmo_r      <= tmo_d;
            any_r      <= any_d;
            kill_r     <= kill_d;
            fork_ack   <= fork_ack_d;
            ch_start   <= ch_start_d;
            ch_kill    <= ch_kill_d;
            pending    <= pending_d;
            busy       <= (state_d != IDLE);
            joined     <= joined_d;
            join_first <= join_first_d;
            timed_out  <= timed_out_d;
            elapsed    <= elapsed_d;
        end
    end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Scoreboard bench for fork_join_ctrl: a transaction-level model predicts output
// events per fork; a monitor pops and compares them as the DUT presents them.
module tb_fork_join_ctrl;

    localparam int N     = 4;
    localparam int TW    = 16;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fork_req = 1'b0;
    logic [N-1:0]  fork_mask = '0;
    logic [1:0]    join_mode = '0;
    logic          kill_on_join = 1'b0;
    logic [TW-1:0] timeout = '0;
    logic [N-1:0]  ch_done = '0;
    logic          fork_ack, busy, joined, timed_out;
    logic [N-1:0]  ch_start, ch_kill, pending;
    logic [1:0]    join_first;
    logic [TW-1:0] elapsed;

    fork_join_ctrl #(.N_CH(N), .TMO_W(TW)) dut (
        .clk(clk), .rst(rst), .fork_req(fork_req), .fork_mask(fork_mask),
        .join_mode(join_mode), .kill_on_join(kill_on_join), .timeout(timeout),
        .ch_done(ch_done), .fork_ack(fork_ack), .ch_start(ch_start),
        .ch_kill(ch_kill), .pending(pending), .busy(busy), .joined(joined),
        .join_first(join_first), .timed_out(timed_out), .elapsed(elapsed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 ack, 1 joined, 2 kill, 3 timeout, 4 busy falls
    typedef struct {
        int           cyc;
        int           kind;
        logic [2*N-1:0] data;
        int           el;
        int           fi;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    bit  mon_en = 1'b0;
    logic busy_q = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic obs(input int kind, input logic [2*N-1:0] data, input int el, input int fi);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind=%0d data=%h at cycle %0d, expected nothing", kind, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data != data ||
                (kind == 1 && (e.el != el || (e.fi >= 0 && e.fi != fi)))) begin
                failures++;
                $display("FAIL event: got kind=%0d cyc=%0d data=%h el=%0d first=%0d, expected kind=%0d cyc=%0d data=%h el=%0d first=%0d",
                         kind, cyc, data, el, fi, e.kind, e.cyc, e.data, e.el, e.fi);
            end
        end
    endtask

    // Monitor: report every output event in a fixed intra-cycle order.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (fork_ack)          obs(0, {pending, ch_start}, 0, 0);
            if (joined)            obs(1, '0, int'(elapsed), int'(join_first));
            if (ch_kill != '0)     obs(2, {pending, ch_kill}, 0, 0);
            if (timed_out)         obs(3, {pending, {N{1'b0}}}, 0, 0);
            if (busy_q && !busy)   obs(4, {pending, {N{1'b0}}}, 0, 0);
        end
        busy_q <= busy;
    end

    function automatic ev_t mk(input int c, input int k, input logic [2*N-1:0] d, input int el, input int fi);
        ev_t e;
        e.cyc = c; e.kind = k; e.data = d; e.el = el; e.fi = fi;
        return e;
    endfunction

    // Reference model: derive the event list from per-channel completion times.
    task automatic predict(input int a, input logic [N-1:0] m, input int mode, input bit kill,
                           input int t, input int d [N], output int fin);
        int e [N];
        int jmin, jmax, first, jt;
        logic [N-1:0] rest;
        bit any_m, none_m;
        any_m  = (mode == 1);
        none_m = (mode == 2);
        jmin = NEVER + 1; jmax = 0; first = -1;
        for (int i = 0; i < N; i++) begin
            e[i] = m[i] ? ((d[i] >= NEVER) ? NEVER + 1 : d[i] + 1) : -1;
            if (m[i] && e[i] > jmax) jmax = e[i];
            if (m[i] && e[i] < jmin) begin jmin = e[i]; first = i; end
        end
        exp_q.push_back(mk(a, 0, {m, m}, 0, 0));
        fin = 0;
        if (m == '0) begin
            exp_q.push_back(mk(a, 1, '0, 0, -1));
            return;
        end
        if (none_m) begin
            exp_q.push_back(mk(a, 1, '0, 0, -1));
            jt = 0;
        end else begin
            jt = any_m ? jmin : jmax;
            if (t > 0 && jt > t) begin
                rest = '0;
                for (int i = 0; i < N; i++) rest[i] = m[i] && (e[i] > t);
                exp_q.push_back(mk(a + t, 2, {{N{1'b0}}, rest}, 0, 0));
                exp_q.push_back(mk(a + t, 3, '0, 0, 0));
                exp_q.push_back(mk(a + t, 4, '0, 0, 0));
                fin = t;
                return;
            end
            exp_q.push_back(mk(a + jt, 1, '0, jt, any_m ? first : -1));
            if (!any_m || jmax == jt) begin
                exp_q.push_back(mk(a + jt, 4, '0, 0, 0));
                fin = jt;
                return;
            end
            if (kill) begin
                rest = '0;
                for (int i = 0; i < N; i++) rest[i] = m[i] && (e[i] > jt);
                exp_q.push_back(mk(a + jt, 2, {{N{1'b0}}, rest}, 0, 0));
                exp_q.push_back(mk(a + jt, 4, '0, 0, 0));
                fin = jt;
                return;
            end
        end
        // Parent released, channels draining.
        if (t > jt && jmax > t) begin
            rest = '0;
            for (int i = 0; i < N; i++) rest[i] = m[i] && (e[i] > t);
            exp_q.push_back(mk(a + t, 2, {{N{1'b0}}, rest}, 0, 0));
            exp_q.push_back(mk(a + t, 3, '0, 0, 0));
            exp_q.push_back(mk(a + t, 4, '0, 0, 0));
            fin = t;
        end else begin
            exp_q.push_back(mk(a + jmax, 4, '0, 0, 0));
            fin = jmax;
        end
    endtask

    // Drive one fork; extra_r >= 0 re-raises fork_req while busy (must be ignored).
    task automatic run_scn(input logic [N-1:0] m, input int mode, input bit kill,
                           input int t, input int d [N], input bit spur, input int extra_r);
        int a, fin, xr;
        @(posedge clk); #1;
        fork_req = 1'b1; fork_mask = m; join_mode = 2'(mode);
        kill_on_join = kill; timeout = TW'(t);
        a = cyc + 1;
        predict(a, m, mode, kill, t, d, fin);
        xr = (m != '0 && fin > 0) ? ((extra_r >= 0) ? extra_r : $urandom_range(fin - 1, 0)) : -1;
        for (int k = 0; k <= fin + 1; k++) begin
            @(posedge clk); #1;
            fork_req = (k == xr);
            fork_mask = 4'($urandom);
            join_mode = 2'($urandom);
            ch_done = '0;
            for (int i = 0; i < N; i++) begin
                if (m[i] && d[i] == k) ch_done[i] = 1'b1;
                if (!m[i] && spur && ($urandom_range(3, 0) == 0)) ch_done[i] = 1'b1;
            end
        end
        @(posedge clk); #1;
        fork_req = 1'b0; ch_done = '0;
        repeat (2) @(posedge clk);
        chk("events_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int d [N];
        logic [N-1:0] m;
        int mode, t;
        bit kill, has_never;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ack_join_tmo", {fork_ack, joined, timed_out, busy}, 0);
        chk("rst_vectors", {ch_start, ch_kill, pending}, 0);
        chk("rst_elapsed_first", {elapsed, join_first}, 0);
        mon_en = 1'b1;

        // 1: JOIN_ALL, done[0]@20, done[1]@30
        d = '{20, 30, NEVER, NEVER};
        run_scn(4'b0011, 0, 1'b0, 0, d, 1'b0, -1);
        // 2: JOIN_ANY no kill
        run_scn(4'b0011, 1, 1'b0, 0, d, 1'b0, -1);
        // 3: JOIN_ANY with kill
        run_scn(4'b0011, 1, 1'b1, 0, d, 1'b0, -1);
        // 4: JOIN_NONE, fork_req again at A+5
        d = '{NEVER, 10, 12, NEVER};
        run_scn(4'b0110, 2, 1'b0, 0, d, 1'b0, 5);
        // 5: timeout with no done, then done just in time
        d = '{NEVER, NEVER, NEVER, NEVER};
        run_scn(4'b0011, 0, 1'b0, 10, d, 1'b0, -1);
        d = '{9, 9, NEVER, NEVER};
        run_scn(4'b0011, 0, 1'b0, 10, d, 1'b0, -1);
        // 6: simultaneous completions, lowest index wins
        d = '{NEVER, NEVER, 5, 5};
        run_scn(4'b1100, 1, 1'b0, 0, d, 1'b0, -1);
        // empty mask and mode 3
        run_scn(4'b0000, 0, 1'b0, 0, d, 1'b0, -1);
        d = '{3, 7, 1, 4};
        run_scn(4'b1111, 3, 1'b0, 0, d, 1'b1, -1);

        // Reset during WAIT: outputs clear, no kill pulse.
        mon_en = 1'b0;
        @(posedge clk); #1;
        fork_req = 1'b1; fork_mask = 4'b0011; join_mode = 2'd0; timeout = '0;
        @(posedge clk); #1;
        fork_req = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_kill", int'(ch_kill), 0);
        chk("midrst_busy_pending", {busy, pending}, 0);
        chk("midrst_pulses", {fork_ack, joined, timed_out, ch_start}, 0);
        @(negedge clk);
        mon_en = 1'b1;
        d = '{20, 30, NEVER, NEVER};
        run_scn(4'b0011, 0, 1'b0, 0, d, 1'b0, -1);

        // Randomized forks.
        for (int n = 0; n < 120; n++) begin
            m    = 4'($urandom);
            mode = $urandom_range(3, 0);
            kill = 1'($urandom);
            t    = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(45, 1);
            has_never = 1'b0;
            for (int i = 0; i < N; i++) begin
                d[i] = ($urandom_range(7, 0) == 0) ? NEVER : $urandom_range(40, 0);
                if (m[i] && d[i] == NEVER) has_never = 1'b1;
            end
            if (has_never && t == 0) t = 45;
            run_scn(m, mode, kill, t, d, 1'b1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
